// File: rtl/multi_mode_checker_pkg.sv
// Shared encodings and helpers for the multi-mode arithmetic checker.
package multi_mode_checker_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_XOR = 2'd2,
        MODE_AND = 2'd3
    } mode_e;

    localparam int WIDTH_MIN   = 2;
    localparam int WIDTH_MAX   = 32;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 16;

    // Galois LFSR, x^32 + x^22 + x^2 + x + 1, shifting right.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ ({32{s[0]}} & 32'h8020_0003);
    endfunction

    // Computed at full 32 bits; callers truncate, which gives mod 2^WIDTH.
    function automatic logic [31:0] golden_op(input mode_e m, input logic [31:0] a,
                                              input logic [31:0] b);
        case (m)
            MODE_ADD: return a + b;
            MODE_SUB: return a - b;
            MODE_XOR: return a ^ b;
            default:  return a & b;
        endcase
    endfunction

endpackage

// File: rtl/multi_mode_checker_if.sv
// Conduit between the checker and the external arithmetic DUT.
interface multi_mode_checker_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] drive_a;
    logic [WIDTH-1:0] drive_b;
    logic             drive_valid;
    logic [WIDTH-1:0] dut_out;

    modport master (output drive_a, output drive_b, output drive_valid, input dut_out);
    modport slave  (input drive_a, input drive_b, input drive_valid, output dut_out);
endinterface

// File: rtl/multi_mode_checker_golden_delay_line.sv
// LATENCY-deep shift register carrying golden results and their valid bits.
module golden_delay_line #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o,
    output logic             any_vld_o
);
    logic [LATENCY-1:0]            vld_pipe_q;
    logic [LATENCY-1:0][WIDTH-1:0] dat_pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            dat_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= vld_i;
            dat_pipe_q[0] <= dat_i;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                dat_pipe_q[i] <= dat_pipe_q[i-1];
            end
        end
    end

    assign vld_o     = vld_pipe_q[LATENCY-1];
    assign dat_o     = dat_pipe_q[LATENCY-1];
    assign any_vld_o = |vld_pipe_q;
endmodule

// File: rtl/multi_mode_checker.sv
// Self-checking stimulus core: LFSR operands out, golden result delayed to DUT latency, compare and count.
module multi_mode_checker
    import multi_mode_checker_pkg::*;
#(
    parameter int          WIDTH   = 16,
    parameter int          LATENCY = 2,
    parameter int          CTR_W   = 32,
    parameter logic [31:0] SEED_A  = 32'hCAFEF00D,
    parameter logic [31:0] SEED_B  = 32'hFEEDC0DE
) (
    input  logic              clk_dut,
    input  logic              reset,
    input  logic              enable,
    input  logic              freeze,
    input  logic [1:0]        i_mode,
    multi_mode_checker_if.master dut,
    output logic [1:0]        o_state,
    output logic [CTR_W-1:0]  o_data_ctr,
    output logic [CTR_W-1:0]  o_event_ctr,
    output logic              o_err_flag,
    output logic [CTR_W-1:0]  o_first_err_idx
);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic [1:0]       state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [31:0]      lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
    logic [WIDTH-1:0] drv_a_q, drv_a_d, drv_b_q, drv_b_d;
    logic             drv_vld_q;
    logic             launch;
    logic [WIDTH-1:0] gold_in, gold_out;
    logic             gold_vld, any_vld;
    logic             cmp_vld_q, cmp_mis_q;
    logic [CTR_W-1:0] data_q, data_d, ev_q, ev_d, first_q, first_d;
    logic             err_q, err_d;

    assign launch = (state_q == ST_RUN) && enable;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: if (enable) begin
                state_d = ST_RUN;
                mode_d  = mode_e'(i_mode);
            end
            ST_RUN:   if (!enable) state_d = ST_DRAIN;
            // Holding until the current stages are empty gives exactly LATENCY drain cycles.
            ST_DRAIN: if (!any_vld) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lfsr_a_d = lfsr_a_q;
        lfsr_b_d = lfsr_b_q;
        drv_a_d  = drv_a_q;
        drv_b_d  = drv_b_q;
        if (launch) begin
            lfsr_a_d = lfsr_next(lfsr_a_q);
            lfsr_b_d = lfsr_next(lfsr_b_q);
            drv_a_d  = lfsr_a_d[WIDTH-1:0];
            drv_b_d  = lfsr_b_d[WIDTH-1:0];
        end
    end

    assign gold_in = WIDTH'(golden_op(mode_q, 32'(drv_a_d), 32'(drv_b_d)));

    golden_delay_line #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_delay (
        .clk       (clk_dut),
        .rst_n     (reset),
        .vld_i     (launch),
        .dat_i     (gold_in),
        .vld_o     (gold_vld),
        .dat_o     (gold_out),
        .any_vld_o (any_vld)
    );

    // Frozen compares are dropped; the first-error index is the pre-increment data count.
    always_comb begin
        data_d  = data_q;
        ev_d    = ev_q;
        err_d   = err_q;
        first_d = first_q;
        if (cmp_vld_q && !freeze) begin
            if (data_q != CTR_MAX) data_d = data_q + CTR_W'(1);
            if (cmp_mis_q) begin
                if (ev_q != CTR_MAX) ev_d = ev_q + CTR_W'(1);
                if (!err_q) begin
                    err_d   = 1'b1;
                    first_d = data_q;
                end
            end
        end
    end

    always_ff @(posedge clk_dut or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_ADD;
            lfsr_a_q  <= SEED_A;
            lfsr_b_q  <= SEED_B;
            drv_a_q   <= '0;
            drv_b_q   <= '0;
            drv_vld_q <= 1'b0;
            cmp_vld_q <= 1'b0;
            cmp_mis_q <= 1'b0;
            data_q    <= '0;
            ev_q      <= '0;
            err_q     <= 1'b0;
            first_q   <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            lfsr_a_q  <= lfsr_a_d;
            lfsr_b_q  <= lfsr_b_d;
            drv_a_q   <= drv_a_d;
            drv_b_q   <= drv_b_d;
            drv_vld_q <= launch;
            cmp_vld_q <= gold_vld;
            cmp_mis_q <= gold_vld && (gold_out != dut.dut_out);
            data_q    <= data_d;
            ev_q      <= ev_d;
            err_q     <= err_d;
            first_q   <= first_d;
        end
    end

    assign dut.drive_a     = drv_a_q;
    assign dut.drive_b     = drv_b_q;
    assign dut.drive_valid = drv_vld_q;
    assign o_state         = state_q;
    assign o_data_ctr      = data_q;
    assign o_event_ctr     = ev_q;
    assign o_err_flag      = err_q;
    assign o_first_err_idx = first_q;
endmodule

// File: tb/tb_multi_mode_checker.sv
// Bench for multi_mode_checker: reference model of operand stream, compare timing and counters.
module tb_multi_mode_checker;
    localparam int NBUF = 4096;
    localparam longint MAX32 = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0, freeze = 1'b0, enable2 = 1'b0;
    logic        freeze2 = 1'b0;
    logic [1:0]  i_mode = 2'd0, mode2 = 2'd0;
    logic [1:0]  st, st2;
    logic [31:0] data_ctr, ev_ctr, first_idx;
    logic        err_flag, err2;
    logic [3:0]  data2, ev2, first2;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    multi_mode_checker_if #(.WIDTH(16)) ifm();
    multi_mode_checker_if #(.WIDTH(16)) ifs();

    multi_mode_checker #(.WIDTH(16), .LATENCY(2), .CTR_W(32)) u_dut (
        .clk_dut(clk), .reset(rst_n), .enable(enable), .freeze(freeze), .i_mode(i_mode),
        .dut(ifm), .o_state(st), .o_data_ctr(data_ctr), .o_event_ctr(ev_ctr),
        .o_err_flag(err_flag), .o_first_err_idx(first_idx));

    multi_mode_checker #(.WIDTH(16), .LATENCY(3), .CTR_W(4)) u_dut2 (
        .clk_dut(clk), .reset(rst_n), .enable(enable2), .freeze(freeze2), .i_mode(mode2),
        .dut(ifs), .o_state(st2), .o_data_ctr(data2), .o_event_ctr(ev2),
        .o_err_flag(err2), .o_first_err_idx(first2));

    function automatic logic [15:0] ref_op(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
        case (m)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: return a ^ b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // External DUT for the main instance: one register stage, optional single-vector corruption.
    logic [1:0]  dut_mode = 2'd0;
    int          err_vec = -1;
    logic [15:0] p_a, p_b;
    logic        p_v;
    int          p_idx, launch_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_a <= '0; p_b <= '0; p_v <= 1'b0; p_idx <= 0; launch_cnt <= 0;
        end else begin
            p_a <= ifm.drive_a; p_b <= ifm.drive_b; p_v <= ifm.drive_valid; p_idx <= launch_cnt;
            if (ifm.drive_valid) launch_cnt <= launch_cnt + 1;
        end
    end
    assign ifm.dut_out = ref_op(dut_mode, p_a, p_b) ^ {15'd0, (p_v && p_idx == err_vec)};

    // Second instance's DUT: a valid-gated adder, tapped after one or two stages.
    logic        dut2_match = 1'b1;
    logic [15:0] q1, q2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= '0; q2 <= '0;
        end else begin
            q1 <= ifs.drive_valid ? ifs.drive_a + ifs.drive_b : 16'd0;
            q2 <= q1;
        end
    end
    assign ifs.dut_out = dut2_match ? q2 : q1;

    // Reference model for the main instance, evaluated just after every edge k.
    logic [1:0]  run_mode = 2'd0;
    logic [15:0] m_gold [NBUF];
    bit          m_gv   [NBUF];
    logic [15:0] m_dut  [NBUF];
    logic [31:0] m_la, m_lb;
    longint      m_data, m_ev, m_first;
    bit          m_err;
    int          cyc;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            cyc = 0; m_la = 32'hCAFEF00D; m_lb = 32'hFEEDC0DE;
            m_data = 0; m_ev = 0; m_first = 0; m_err = 0;
        end else begin
            int t;
            cyc++;
            if (ifm.drive_valid) begin
                m_la = ref_lfsr(m_la);
                m_lb = ref_lfsr(m_lb);
                chk("drive_a", ifm.drive_a, m_la[15:0]);
                chk("drive_b", ifm.drive_b, m_lb[15:0]);
                m_gold[cyc % NBUF] = ref_op(run_mode, m_la[15:0], m_lb[15:0]);
                m_gv[cyc % NBUF] = 1'b1;
            end else begin
                m_gv[cyc % NBUF] = 1'b0;
            end
            m_dut[(cyc + 1) % NBUF] = ifm.dut_out;
            // Vector launched at edge t sees the DUT at t+2 and lands in the counters at t+3.
            t = cyc - 3;
            if (t >= 1 && m_gv[t % NBUF] && !freeze) begin
                longint pre;
                pre = m_data;
                if (m_data < MAX32) m_data++;
                if (m_gold[t % NBUF] != m_dut[(t + 2) % NBUF]) begin
                    if (m_ev < MAX32) m_ev++;
                    if (!m_err) begin m_err = 1; m_first = pre; end
                end
            end
            chk("data_ctr", data_ctr, m_data);
            chk("event_ctr", ev_ctr, m_ev);
            chk("err_flag", err_flag, m_err);
            chk("first_err_idx", first_idx, m_first);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b0; enable2 = 1'b0; freeze = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // n launches; freeze covers updates of vectors flo..fhi; optional mode toggle and state/first-vector checks.
    task automatic run_main(input int n, input int flo, input int fhi, input bit toggle, input bit chk_first);
        @(negedge clk);
        i_mode = run_mode;
        enable = 1'b1;
        for (int c = 0; c < n + 6; c++) begin
            @(negedge clk);
            if (chk_first && c == 1) begin
                chk("first_drive_a", ifm.drive_a, 16'h7805);
                chk("first_drive_b", ifm.drive_b, 16'hE06F);
                chk("first_drive_valid", ifm.drive_valid, 1);
            end
            if (c == n + 1) begin
                chk("state_drain0", st, 2);
                chk("drain_valid", ifm.drive_valid, 0);
            end
            if (c == n + 2) chk("state_drain1", st, 2);
            if (c == n + 3) chk("state_idle", st, 0);
            enable = (c + 1 <= n);
            freeze = (c - 3 >= flo) && (c - 3 <= fhi);
            if (toggle && c == 3) i_mode = 2'd2;
        end
        freeze = 1'b0;
        i_mode = run_mode;
    endtask

    task automatic run2(input int n);
        @(negedge clk);
        enable2 = 1'b1;
        for (int c = 0; c < n + 8; c++) begin
            @(negedge clk);
            enable2 = (c + 1 <= n);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", st, 0);
        chk("rst_data", data_ctr, 0);
        chk("rst_event", ev_ctr, 0);
        chk("rst_err", err_flag, 0);
        chk("rst_first", first_idx, 0);
        chk("rst_drive_a", ifm.drive_a, 0);
        chk("rst_drive_b", ifm.drive_b, 0);
        chk("rst_valid", ifm.drive_valid, 0);
        rst_n = 1'b1;

        // Loopback adder, 100 vectors
        run_mode = 2'd0; dut_mode = 2'd0; err_vec = -1;
        run_main(100, -1, -1, 1'b0, 1'b1);
        chk("t1_data", data_ctr, 100);
        chk("t1_event", ev_ctr, 0);
        chk("t1_err", err_flag, 0);

        // Fifth vector corrupted
        do_reset();
        err_vec = 4;
        run_main(10, -1, -1, 1'b0, 1'b1);
        chk("t2_data", data_ctr, 10);
        chk("t2_event", ev_ctr, 1);
        chk("t2_first", first_idx, 4);
        chk("t2_err", err_flag, 1);
        err_vec = -1;

        // Narrow counters saturate
        do_reset();
        dut2_match = 1'b1;
        run2(20);
        chk("t3_data_sat", data2, 15);
        chk("t3_event", ev2, 0);
        chk("t3_err", err2, 0);

        // Latency mismatch: every compare fails
        do_reset();
        dut2_match = 1'b0;
        run2(10);
        chk("t4_data", data2, 10);
        chk("t4_event", ev2, 10);
        chk("t4_first", first2, 0);
        chk("t4_err", err2, 1);
        dut2_match = 1'b1;

        // Subtract with a freeze window and a mode toggle mid-run
        do_reset();
        run_mode = 2'd1; dut_mode = 2'd1;
        run_main(30, 10, 19, 1'b1, 1'b0);
        chk("t5_data", data_ctr, 20);
        chk("t5_event", ev_ctr, 0);
        chk("t5_err", err_flag, 0);

        // Reset during RUN after 7 vectors
        do_reset();
        run_mode = 2'd0; dut_mode = 2'd0;
        @(negedge clk);
        i_mode = 2'd0;
        enable = 1'b1;
        repeat (8) @(negedge clk);
        chk("pre_rst_data_nonzero", (data_ctr != 0), 1);
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("mid_rst_state", st, 0);
        chk("mid_rst_data", data_ctr, 0);
        chk("mid_rst_drive_a", ifm.drive_a, 0);
        chk("mid_rst_valid", ifm.drive_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_main(5, -1, -1, 1'b0, 1'b1);
        chk("t6_data", data_ctr, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
